// File: rtl/exhaustive_checker_pkg.sv
// Shared definitions for the exhaustive truth-table checker: the FSM state
// encoding, the number of input vectors in a sweep, and the result bundle.
package exhaustive_pkg;

  localparam int NUM_VECTORS = 16;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DRIVE = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  typedef struct packed {
    logic [4:0] err_count;
    logic       fail_valid;
    logic [3:0] first_fail;
  } result_t;

endpackage

// File: rtl/exhaustive_checker_if.sv
// Bundle between the checker and the outside world: start request, the
// response of the external device under test, the stimulus and the results.
interface exhaustive_checker_if;

  logic       start;
  logic       f_in;
  logic [3:0] abcd;
  logic       busy;
  logic       done;
  logic       pass;
  logic [4:0] err_count;
  logic       fail_valid;
  logic [3:0] first_fail;

  modport slave (
    input  start, f_in,
    output abcd, busy, done, pass, err_count, fail_valid, first_fail
  );

  modport master (
    output start, f_in,
    input  abcd, busy, done, pass, err_count, fail_valid, first_fail
  );

endinterface

// File: rtl/exhaustive_checker_hold_timer.sv
// Dwell counter: counts the cycles a vector has been applied and flags the
// last cycle of the dwell so the response can be sampled there.
module hold_timer #(
  parameter int HOLD = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);

  logic [7:0] cnt_q, cnt_d;

  // Next count: clear wins over counting so a new vector starts from zero.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  // Count register, forced to zero by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = (cnt_q == 8'(HOLD - 1));

endmodule

// File: rtl/exhaustive_checker.sv
// Sweeps all 16 input combinations into an external device, holds each for
// HOLD cycles, samples the response on the last cycle of the dwell and
// compares it with the golden truth table, accumulating mismatch statistics.
module exhaustive_checker
  import exhaustive_pkg::*;
#(
  parameter int          HOLD     = 20,
  parameter logic [15:0] EXPECTED = 16'h0000
) (
  input logic                 clk,
  input logic                 rst_n,
  exhaustive_checker_if.slave bus
);

  logic [1:0] state_q, state_d;
  logic [3:0] vec_q, vec_d;
  result_t    res_q, res_d;

  logic start_ok;
  logic sample;
  logic mismatch;
  logic expire;
  logic timer_clr;
  logic last_vec;

  // start only counts when no sweep is running; the sample strobe is the
  // final dwell cycle of the current vector.
  assign start_ok  = bus.start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign sample    = (state_q == ST_DRIVE) && expire;
  assign mismatch  = sample && (bus.f_in != EXPECTED[vec_q]);
  assign last_vec  = (vec_q == 4'(NUM_VECTORS - 1));
  assign timer_clr = start_ok || sample;

  hold_timer #(
    .HOLD(HOLD)
  ) u_hold_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (timer_clr),
    .en    (state_q == ST_DRIVE),
    .expire(expire)
  );

  // Sequencing and result accumulation; the vector index stops at 15 so the
  // stimulus stays at 4'hF once the sweep has finished.
  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    res_d   = res_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_ok) begin
          state_d = ST_DRIVE;
          vec_d   = 4'd0;
          res_d   = '0;
        end
      end
      ST_DRIVE: begin
        if (mismatch) begin
          res_d.err_count = res_q.err_count + 5'd1;
          if (!res_q.fail_valid) begin
            res_d.fail_valid = 1'b1;
            res_d.first_fail = vec_q;
          end
        end
        if (sample) begin
          if (last_vec) begin
            state_d = ST_DONE;
          end else begin
            vec_d = vec_q + 4'd1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        vec_d   = 4'd0;
        res_d   = '0;
      end
    endcase
  end

  // State, vector and result registers; reset aborts any sweep in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      vec_q   <= 4'd0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      res_q   <= res_d;
    end
  end

  assign bus.abcd       = vec_q;
  assign bus.busy       = (state_q == ST_DRIVE);
  assign bus.done       = (state_q == ST_DONE);
  assign bus.pass       = (state_q == ST_DONE) && (res_q.err_count == 5'd0);
  assign bus.err_count  = res_q.err_count;
  assign bus.fail_valid = res_q.fail_valid;
  assign bus.first_fail = res_q.first_fail;

endmodule

// File: tb/tb_exhaustive_checker.sv
// Bench for the exhaustive checker: two instances (a long-dwell one with a
// step-function golden table and a minimum-dwell one with an all-zero table),
// a reference model of the sweep results fed into a scoreboard queue, and
// cycle-by-cycle monitoring of the stimulus during every sweep.
module tb_exhaustive_checker;
  import exhaustive_pkg::*;

  localparam int          H1   = 4;
  localparam logic [15:0] EXP1 = 16'hFF00;
  localparam int          H2   = 2;
  localparam logic [15:0] EXP2 = 16'h0000;

  typedef struct {
    int errCount;
    int failValid;
    int firstFail;
    int pass;
    int cycles;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic sel   = 1'b0;
  int   fMode = 0;

  int   errors = 0;
  int   checks = 0;
  exp_t sbq[$];

  exhaustive_checker_if if1 ();
  exhaustive_checker_if if2 ();

  // fMode 0: device is f = A; 1: f stuck at 0; 2: f stuck at 1.
  assign if1.f_in = (fMode == 0) ? if1.abcd[3] : (fMode == 2);
  assign if2.f_in = 1'b1;

  exhaustive_checker #(.HOLD(H1), .EXPECTED(EXP1)) u_dut1 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (if1)
  );

  exhaustive_checker #(.HOLD(H2), .EXPECTED(EXP2)) u_dut2 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (if2)
  );

  always #5 clk = ~clk;

  logic [3:0] oAbcd;
  logic       oBusy, oDone, oPass, oFv;
  logic [4:0] oErr;
  logic [3:0] oFf;

  assign oAbcd = sel ? if2.abcd       : if1.abcd;
  assign oBusy = sel ? if2.busy       : if1.busy;
  assign oDone = sel ? if2.done       : if1.done;
  assign oPass = sel ? if2.pass       : if1.pass;
  assign oErr  = sel ? if2.err_count  : if1.err_count;
  assign oFv   = sel ? if2.fail_valid : if1.fail_valid;
  assign oFf   = sel ? if2.first_fail : if1.first_fail;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic exp_t modelSweep(input int mode, input logic [15:0] golden, input int hold);
    exp_t e;
    int   f;
    e.errCount  = 0;
    e.failValid = 0;
    e.firstFail = 0;
    for (int v = 0; v < 16; v++) begin
      f = (mode == 0) ? ((v >> 3) & 1) : ((mode == 2) ? 1 : 0);
      if (f != int'(golden[v])) begin
        e.errCount++;
        if (e.failValid == 0) begin
          e.failValid = 1;
          e.firstFail = v;
        end
      end
    end
    e.pass   = (e.errCount == 0) ? 1 : 0;
    e.cycles = 16 * hold;
    return e;
  endfunction

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " abcd"}, oAbcd, 0);
    checkOutput({tag, " busy"}, oBusy, 0);
    checkOutput({tag, " done"}, oDone, 0);
    checkOutput({tag, " pass"}, oPass, 0);
    checkOutput({tag, " err_count"}, oErr, 0);
    checkOutput({tag, " fail_valid"}, oFv, 0);
    checkOutput({tag, " first_fail"}, oFf, 0);
  endtask

  task automatic driveStart(input logic which, input logic val);
    if (which) if2.start = val;
    else       if1.start = val;
  endtask

  task automatic applyStimulus(input logic which);
    @(negedge clk);
    driveStart(which, 1'b1);
    @(negedge clk);
    driveStart(which, 1'b0);
  endtask

  // Runs one sweep; restartVec re-pulses start while that vector is applied,
  // abortVec pulls reset while that vector is applied (negative = unused).
  task automatic runSweep(input logic which, input int mode, input int hold,
                          input logic [15:0] golden, input int restartVec, input int abortVec);
    int   cycles;
    bit   aborted;
    exp_t e;
    sel    = which;
    fMode  = mode;
    cycles = 0;
    aborted = 0;
    sbq.push_back(modelSweep(mode, golden, hold));
    applyStimulus(which);
    checkOutput("first drive done", oDone, 0);
    checkOutput("first drive err_count", oErr, 0);
    checkOutput("first drive fail_valid", oFv, 0);
    while (!oDone && !aborted && cycles < 16 * hold + 8) begin
      checkOutput("abcd during sweep", oAbcd, cycles / hold);
      checkOutput("busy during sweep", oBusy, 1);
      if (abortVec >= 0 && cycles == abortVec * hold + 1) begin
        #1;
        rst_n = 1'b0;
        #1;
        checkAllZero("async reset");
        void'(sbq.pop_front());
        aborted = 1;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checkAllZero("idle after reset");
      end else begin
        if (restartVec >= 0 && cycles == restartVec * hold + 1) driveStart(which, 1'b1);
        @(negedge clk);
        driveStart(which, 1'b0);
        cycles++;
      end
    end
    if (!aborted) begin
      e = sbq.pop_front();
      if (!oDone) begin
        checkOutput("done timeout", 0, 1);
      end else begin
        checkOutput("sweep cycles", cycles, e.cycles);
        checkOutput("err_count", oErr, e.errCount);
        checkOutput("fail_valid", oFv, e.failValid);
        if (e.failValid != 0) checkOutput("first_fail", oFf, e.firstFail);
        checkOutput("pass", oPass, e.pass);
        checkOutput("abcd in done", oAbcd, 15);
        checkOutput("busy in done", oBusy, 0);
        repeat (5) @(negedge clk);
        checkOutput("done held", oDone, 1);
        checkOutput("err_count held", oErr, e.errCount);
        checkOutput("fail_valid held", oFv, e.failValid);
        checkOutput("pass held", oPass, e.pass);
      end
    end
  endtask

  initial begin
    if1.start = 1'b0;
    if2.start = 1'b0;
    repeat (2) @(negedge clk);
    sel = 1'b0;
    checkAllZero("reset dut1");
    sel = 1'b1;
    checkAllZero("reset dut2");
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    sel = 1'b0;
    checkOutput("idle without start busy", oBusy, 0);
    checkOutput("idle without start done", oDone, 0);

    $display("[TB] sweep: f = A, golden FF00");
    runSweep(1'b0, 0, H1, EXP1, -1, -1);
    $display("[TB] sweep: f = 0, start re-pulsed at vector 7");
    runSweep(1'b0, 1, H1, EXP1, 7, -1);
    $display("[TB] sweep: restart from DONE, f = A");
    runSweep(1'b0, 0, H1, EXP1, -1, -1);
    $display("[TB] sweep: HOLD=2, f = 1, golden 0000");
    runSweep(1'b1, 2, H2, EXP2, -1, -1);
    $display("[TB] sweep: reset at vector 5, then clean sweep");
    runSweep(1'b0, 2, H1, EXP1, -1, 5);
    runSweep(1'b0, 2, H1, EXP1, -1, -1);

    checkOutput("scoreboard drained", sbq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/exhaustive_checker.md
EXHAUSTIVE_CHECKER -- requirements
Module: exhaustive_checker

Interface
REQ-001 Parameter HOLD, default 20: clock cycles each input vector is held (legal range 2..255).
REQ-002 Parameter EXPECTED, default 16'h0000: golden truth table; bit [v] is the expected f for input vector v.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 start  input  1  begin a full 16-vector sweep; sampled in IDLE or DONE only.
REQ-006 f_in  input  1  response of the device under test.
REQ-007 abcd  output  4  stimulus to the device under test as {A,B,C,D}, A = MSB.
REQ-008 busy  output  1  high while a sweep is in progress.
REQ-009 done  output  1  high once a sweep has completed; held until the next start or reset.
REQ-010 pass  output  1  valid when done; high iff err_count == 0.
REQ-011 err_count  output  5  number of mismatching vectors (0..16).
REQ-012 fail_valid  output  1  high once at least one mismatch has been recorded.
REQ-013 first_fail  output  4  vector index of the first mismatch; meaningful only when fail_valid = 1.

Function
REQ-014 The FSM shall have states IDLE, DRIVE and DONE.
REQ-015 IDLE/DONE + start=1: next state DRIVE; vec=0, hold counter=0, err_count=0, fail_valid=0, first_fail=0, done=0.
REQ-016 DRIVE: abcd shall equal vec every cycle; the hold counter increments each cycle.
REQ-017 DRIVE, hold counter == HOLD-1: f_in is sampled and compared with EXPECTED[vec] in that cycle.
REQ-018 Mismatch: err_count increments by 1 (no saturation needed; max 16 fits in 5 bits).
REQ-019 Mismatch with fail_valid=0: first_fail=vec and fail_valid=1; later mismatches leave first_fail unchanged.
REQ-020 Sample cycle with vec < 15: vec increments and the hold counter clears; state stays DRIVE.
REQ-021 Sample cycle with vec == 15: next state DONE; abcd holds 4'hF; vec does not wrap.
REQ-022 A full sweep shall take exactly 16*HOLD cycles from the first DRIVE cycle to the first DONE cycle.
REQ-023 start asserted while in DRIVE shall be ignored; the sweep is not restarted.
REQ-024 busy = (state == DRIVE); done = (state == DONE); pass = done && (err_count == 0).
REQ-025 In IDLE, abcd shall drive 4'h0.
REQ-026 Results (err_count, fail_valid, first_fail) shall remain stable in DONE until the next accepted start.

Reset
REQ-027 rst_n low shall force the following immediately, regardless of clock: state=IDLE, abcd=0, busy=0, done=0, pass=0, err_count=0, fail_valid=0, first_fail=0, hold counter=0.
REQ-028 Reset asserted mid-sweep shall abort the sweep; no partial result shall be retained.
REQ-029 After rst_n rises, the block shall idle until start is asserted.

Structure
REQ-030 The state encoding (IDLE, DRIVE, DONE) and the vector count constant (16) shall live in a shared package, exhaustive_pkg.
REQ-031 The hold counter shall be a sub-module, hold_timer, with inputs clr and en and output expire; expire is asserted when the count reaches HOLD-1.
REQ-032 The device under test shall not be instantiated inside the block; it is connected externally via abcd and f_in.

Verification
REQ-033 Scenario 1: EXPECTED=16'hFF00, f_in tied to abcd[3], start pulse -> done after 16*HOLD cycles, pass=1, err_count=0, fail_valid=0.
REQ-034 Scenario 2: EXPECTED=16'hFF00, f_in tied to 0 -> err_count=8, first_fail=4'h8, fail_valid=1, pass=0.
REQ-035 Scenario 3: HOLD=2, f_in tied to 1, EXPECTED=16'h0000 -> err_count=16, first_fail=0; done exactly 32 cycles after the first DRIVE cycle.
REQ-036 Scenario 4: rst_n pulsed low at vec=5 -> all outputs 0 asynchronously, state IDLE; a new start yields a clean full sweep.
REQ-037 Scenario 5: start re-pulsed at vec=7 during DRIVE -> ignored, sweep finishes normally; start pulsed in DONE -> results cleared and a new sweep runs.
REQ-038 Scenario 6: abcd monitored during a sweep -> each value 0..15 is held exactly HOLD cycles, in ascending order.
